// File: rtl/capture_wr_ctrl.sv
// Capture-side DDR write controller: buffers pixel words with per-frame slot addresses
// and drains them to the DDR write port over valid/ready, reporting per-frame completion.
module capture_wr_ctrl #(
   parameter int          FIFO_DEPTH   = 16,
   parameter int          FRAME_WORDS  = 38400,
   parameter int          ADDR_STEP    = 4,
   parameter logic [24:0] FRAME_STRIDE = 25'h25800
) (
   input  logic          p_clk,
   input  logic          rst,
   input  logic [127:0]  p_data,
   input  logic          data_valid,
   input  logic          frame_done,
   input  logic [2:0]    frame_slot,
   input  logic          hold,
   output logic          mem_wr_valid,
   output logic [24:0]   mem_wr_addr,
   output logic [127:0]  mem_wr_data,
   input  logic          mem_wr_ready,
   output logic          frame_wr_done,
   output logic [15:0]   frame_words,
   output logic          overflow,
   output logic          overrun,
   output logic          done_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [24:0]  addr;
      logic [127:0] data;
   } entry_t;

   entry_t             mem [FIFO_DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   occ, occ_next;
   logic [CNT_W-1:0]   countdown;
   logic [24:0]        last_addr, base_addr, push_addr;
   logic [15:0]        word_cnt;
   logic               armed, pending;
   logic               accept, pop, push, full, at_limit;

   assign accept    = data_valid & ~hold;
   assign full      = (occ == CNT_W'(FIFO_DEPTH));
   assign at_limit  = (word_cnt == 16'(FRAME_WORDS));
   assign pop       = mem_wr_valid & mem_wr_ready;
   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign push      = accept & ~at_limit & (~full | pop);

   assign base_addr = FRAME_STRIDE * 25'(frame_slot);
   assign push_addr = armed ? base_addr : last_addr + 25'(ADDR_STEP);

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      occ_next = occ;
      case ({push, pop})
         2'b10:   occ_next = occ + 1'b1;
         2'b01:   occ_next = occ - 1'b1;
         default: occ_next = occ;
      endcase
   end

   // NOTE: the storage array is deliberately not reset; occupancy alone decides what is visible.
   always_ff @(posedge p_clk) begin
      if (push) mem[wr_ptr] <= '{addr: push_addr, data: p_data};
   end

   // NOTE: non-blocking assignments for all state; the later assignment wins, so frame_done re-arms
   // even when the same cycle's push cleared armed.
   always_ff @(posedge p_clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         armed       <= 1'b1;
         last_addr   <= '0;
         word_cnt    <= '0;
         frame_words <= '0;
         pending     <= 1'b0;
         countdown   <= '0;
         overflow    <= 1'b0;
         overrun     <= 1'b0;
         done_err    <= 1'b0;
      end else begin
         occ <= occ_next;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;
            last_addr <= push_addr;
            armed     <= 1'b0;
         end
         if (accept & at_limit)                 overrun  <= 1'b1;
         if (accept & ~at_limit & full & ~pop)  overflow <= 1'b1;

         if (frame_done) begin
            // A word arriving with frame_done belongs to the ending frame.
            frame_words <= word_cnt + 16'(push);
            word_cnt    <= '0;
            armed       <= 1'b1;
            countdown   <= occ_next;
            pending     <= 1'b1;
            if (pending) done_err <= 1'b1;
         end else begin
            if (push) word_cnt <= word_cnt + 1'b1;
            if (pending) begin
               if (countdown == '0)  pending   <= 1'b0;
               else if (pop)         countdown <= countdown - 1'b1;
            end
         end
      end
   end

   assign head          = mem[rd_ptr];
   assign mem_wr_valid  = (occ != '0);
   assign mem_wr_addr   = mem_wr_valid ? head.addr : '0;
   assign mem_wr_data   = mem_wr_valid ? head.data : '0;
   assign frame_wr_done = pending & (countdown == '0);

endmodule

// File: tb/tb_capture_wr_ctrl.sv
// Bench for capture_wr_ctrl: directed table, corner-case sequences and random traffic
// compared against a queue-based reference model.
module tb_capture_wr_ctrl;

   localparam int          DEPTH  = 16;
   localparam int          FW     = 24;
   localparam int          STEP   = 4;
   localparam logic [24:0] STRIDE = 25'h25800;
   localparam bit H = 1'b1;
   localparam bit L = 1'b0;
   localparam logic [127:0] DA = {4{32'hA5A5A5A5}};
   localparam logic [127:0] D1 = {4{32'h11111111}};
   localparam logic [127:0] D2 = {4{32'h22222222}};
   localparam logic [127:0] DH = {4{32'hDEADBEEF}};
   localparam logic [127:0] DZ = '0;

   logic          p_clk, rst, data_valid, frame_done, hold, mem_wr_ready;
   logic [127:0]  p_data, mem_wr_data;
   logic [2:0]    frame_slot;
   logic          mem_wr_valid, frame_wr_done, overflow, overrun, done_err;
   logic [24:0]   mem_wr_addr;
   logic [15:0]   frame_words;

   capture_wr_ctrl #(
      .FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW), .ADDR_STEP(STEP), .FRAME_STRIDE(STRIDE)
   ) dut (
      .p_clk(p_clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .frame_done(frame_done), .frame_slot(frame_slot), .hold(hold),
      .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ready(mem_wr_ready), .frame_wr_done(frame_wr_done), .frame_words(frame_words),
      .overflow(overflow), .overrun(overrun), .done_err(done_err)
   );

   initial p_clk = 1'b0;
   always #5 p_clk = ~p_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: FIFO as a queue, completion tracked by total push/pop counts.
   typedef struct packed { logic [24:0] addr; logic [127:0] data; } ent_t;
   ent_t        q[$];
   bit          m_armed, m_pending, m_ovf, m_ovr, m_derr;
   logic [24:0] m_addr;
   int          m_cnt, m_target, pushes, pops;
   logic [15:0] m_words;

   task automatic model_update(input logic r, dv, input logic [127:0] d, input logic fd,
                               input logic [2:0] s, input logic h, rdy);
      bit pop, push, done_now;
      logic [24:0] a;
      if (r) begin
         q.delete();
         m_armed = 1; m_pending = 0; m_ovf = 0; m_ovr = 0; m_derr = 0;
         m_addr = '0; m_cnt = 0; m_target = 0; pushes = 0; pops = 0; m_words = '0;
         return;
      end
      pop      = (q.size() > 0) && rdy;
      done_now = m_pending && (pops >= m_target);
      push     = 0;
      if (dv && !h) begin
         if (m_cnt == FW)                      m_ovr = 1;
         else if (q.size() == DEPTH && !pop)   m_ovf = 1;
         else                                  push = 1;
      end
      if (pop) begin q.delete(0); pops++; end
      if (push) begin
         a = m_armed ? 25'(longint'(s) * longint'(STRIDE)) : m_addr + 25'(STEP);
         m_armed = 0; m_addr = a;
         q.push_back('{addr: a, data: d});
         pushes++; m_cnt++;
      end
      if (fd) begin
         m_words = 16'(m_cnt); m_cnt = 0; m_armed = 1;
         if (m_pending) m_derr = 1;
         m_pending = 1; m_target = pushes;
      end else if (done_now) begin
         m_pending = 0;
      end
   endtask

   logic [24:0] wr_log[$];
   int done_cnt = 0;

   // One clock: drive at negedge, advance model at posedge, settle to the next negedge.
   task automatic step(input logic r, dv, input logic [127:0] d, input logic fd,
                       input logic [2:0] s, input logic h, rdy);
      rst = r; data_valid = dv; p_data = d; frame_done = fd;
      frame_slot = s; hold = h; mem_wr_ready = rdy;
      if (!r && mem_wr_valid === 1'b1 && rdy) wr_log.push_back(mem_wr_addr);
      @(posedge p_clk);
      model_update(r, dv, d, fd, s, h, rdy);
      @(negedge p_clk);
      if (frame_wr_done === 1'b1) done_cnt++;
   endtask

   task automatic check_model();
      bit ev;
      ev = q.size() > 0;
      check("valid", mem_wr_valid, ev);
      if (ev) begin
         check("addr", mem_wr_addr, q[0].addr);
         check("data", mem_wr_data, q[0].data);
      end
      check("frame_wr_done", frame_wr_done, m_pending && (pops >= m_target));
      check("frame_words", frame_words, m_words);
      check("overflow", overflow, m_ovf);
      check("overrun", overrun, m_ovr);
      check("done_err", done_err, m_derr);
   endtask

   task automatic mstep(input logic r, dv, input logic [127:0] d, input logic fd,
                        input logic [2:0] s, input logic h, rdy);
      step(r, dv, d, fd, s, h, rdy);
      check_model();
   endtask

   task automatic do_reset();
      mstep(H, L, DZ, L, 3'd0, L, L);
      mstep(H, L, DZ, L, 3'd0, L, L);
      wr_log.delete();
      done_cnt = 0;
   endtask

   typedef struct {
      bit dv, fd, hold, rdy; logic [2:0] slot; logic [127:0] d;
      bit ev; logic [24:0] ea; logic [127:0] ed; bit edone; logic [15:0] ew;
   } vec_t;
   vec_t tbl[11];

   initial begin
      tbl[0]  = '{H, L, L, H, 3'd1, DA, H, 25'h25800, DA, L, 16'd0};
      tbl[1]  = '{L, L, L, H, 3'd1, DZ, L, 25'h0,     DZ, L, 16'd0};
      tbl[2]  = '{L, H, L, H, 3'd1, DZ, L, 25'h0,     DZ, H, 16'd1};
      tbl[3]  = '{L, L, L, H, 3'd1, DZ, L, 25'h0,     DZ, L, 16'd1};
      tbl[4]  = '{H, L, H, H, 3'd2, DH, L, 25'h0,     DZ, L, 16'd1};
      tbl[5]  = '{H, L, L, L, 3'd2, D1, H, 25'h4B000, D1, L, 16'd1};
      tbl[6]  = '{H, L, L, L, 3'd2, D2, H, 25'h4B000, D1, L, 16'd1};
      tbl[7]  = '{L, L, L, H, 3'd2, DZ, H, 25'h4B004, D2, L, 16'd1};
      tbl[8]  = '{L, H, L, L, 3'd2, DZ, H, 25'h4B004, D2, L, 16'd2};
      tbl[9]  = '{L, L, L, H, 3'd2, DZ, L, 25'h0,     DZ, H, 16'd2};
      tbl[10] = '{L, L, L, H, 3'd2, DZ, L, 25'h0,     DZ, L, 16'd2};

      // Reset state: every output zero.
      do_reset();
      check("reset addr", mem_wr_addr, 25'h0);
      check("reset data", mem_wr_data, DZ);

      // Directed table: single word, zero-occupancy completion, hold, backpressure.
      foreach (tbl[i]) begin
         step(L, tbl[i].dv, tbl[i].d, tbl[i].fd, tbl[i].slot, tbl[i].hold, tbl[i].rdy);
         check($sformatf("tbl%0d valid", i), mem_wr_valid, tbl[i].ev);
         if (tbl[i].ev) begin
            check($sformatf("tbl%0d addr", i), mem_wr_addr, tbl[i].ea);
            check($sformatf("tbl%0d data", i), mem_wr_data, tbl[i].ed);
         end
         check($sformatf("tbl%0d done", i), frame_wr_done, tbl[i].edone);
         check($sformatf("tbl%0d words", i), frame_words, tbl[i].ew);
      end

      // Full frame in slot 5 with ready held high.
      do_reset();
      for (int i = 0; i < FW; i++) mstep(L, H, 128'(i), L, 3'd5, L, H);
      mstep(L, L, DZ, H, 3'd5, L, H);
      for (int i = 0; i < 3; i++) mstep(L, L, DZ, L, 3'd5, L, H);
      check("full count", wr_log.size(), FW);
      check("full first", wr_log[0], 25'hBB800);
      check("full last", wr_log[FW-1], 25'hBB800 + 25'(4 * (FW - 1)));
      check("full words", frame_words, 16'(FW));
      check("full flags", {overflow, overrun, done_err}, 3'b000);
      check("full done pulses", done_cnt, 1);

      // Overrun: two words beyond the frame limit.
      do_reset();
      for (int i = 0; i < FW + 2; i++) mstep(L, H, 128'(i), L, 3'd0, L, H);
      mstep(L, L, DZ, H, 3'd0, L, H);
      for (int i = 0; i < 2; i++) mstep(L, L, DZ, L, 3'd0, L, H);
      check("overrun count", wr_log.size(), FW);
      check("overrun flag", overrun, 1'b1);
      check("overrun words", frame_words, 16'(FW));

      // Backpressure: 17 words into 16 entries, then release.
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) mstep(L, H, 128'(i), L, 3'd3, L, L);
      check("bp overflow", overflow, 1'b1);
      for (int i = 0; i < DEPTH + 4; i++) mstep(L, L, DZ, L, 3'd3, L, H);
      check("bp count", wr_log.size(), DEPTH);
      foreach (wr_log[i]) check($sformatf("bp addr%0d", i), wr_log[i], 25'h70800 + 25'(4 * i));

      // Pending drain with a new-frame word queued behind the old frame.
      do_reset();
      for (int i = 0; i < 3; i++) mstep(L, H, 128'(i + 1), L, 3'd1, L, L);
      mstep(L, L, DZ, H, 3'd6, L, L);
      mstep(L, H, DH, L, 3'd6, L, L);
      for (int i = 0; i < 3; i++) mstep(L, L, DZ, L, 3'd6, L, L);
      check("drain early done", done_cnt, 0);
      begin
         int pop3 = -1, dstep = -1;
         for (int k = 0; k < 10; k++) begin
            mstep(L, L, DZ, L, 3'd6, L, H);
            if (wr_log.size() >= 3 && pop3 < 0) pop3 = k;
            if (frame_wr_done === 1'b1 && dstep < 0) dstep = k;
         end
         check("drain done timing", dstep, pop3);
      end
      check("drain done pulses", done_cnt, 1);
      check("drain new base", wr_log[3], 25'hE1000);

      // Double frame_done while completion pending.
      do_reset();
      for (int i = 0; i < 2; i++) mstep(L, H, 128'(i), L, 3'd2, L, L);
      mstep(L, L, DZ, H, 3'd2, L, L);
      mstep(L, L, DZ, H, 3'd2, L, L);
      for (int i = 0; i < 5; i++) mstep(L, L, DZ, L, 3'd2, L, H);
      check("double done_err", done_err, 1'b1);
      check("double pulses", done_cnt, 1);

      // Reset with words queued, then hold.
      do_reset();
      for (int i = 0; i < 4; i++) mstep(L, H, 128'(i), L, 3'd2, L, L);
      mstep(H, L, DZ, L, 3'd2, L, L);
      check("rst valid", mem_wr_valid, 1'b0);
      mstep(L, H, D1, L, 3'd4, L, L);
      check("rst new base", mem_wr_addr, 25'h96000);
      for (int i = 0; i < 3; i++) mstep(L, H, D2, L, 3'd4, H, L);
      mstep(L, L, DZ, H, 3'd4, L, H);
      check("hold words", frame_words, 16'd1);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         mstep(logic'($urandom_range(0, 999) == 0), logic'($urandom_range(0, 1)),
               {$urandom, $urandom, $urandom, $urandom}, logic'($urandom_range(0, 59) == 0),
               3'($urandom_range(0, 7)), logic'($urandom_range(0, 7) == 0),
               logic'($urandom_range(0, 9) < 6));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
